// File: rtl/param_wb_burst.sv
// Burst write-back buffer: collects up to BURST_LEN words from a PVR client,
// then replays them as one Avalon-style write burst to the DDRAM arbiter.
module param_wb_burst #(
  parameter int BURST_LEN = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [21:0] wr_addr,
  input  logic        wr_start,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  input  logic        wr_flush,
  output logic        wr_ready,
  output logic        wr_busy,
  output logic        wr_done,
  input  logic        ddram_waitrequest,
  output logic [21:0] ddram_addr,
  output logic [5:0]  ddram_burstcnt,
  output logic        ddram_write,
  output logic [31:0] ddram_writedata
);

  localparam int         IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [5:0] LEN6  = 6'(BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [5:0]  beat_q, beat_d;
  logic [5:0]  burstcnt_q, burstcnt_d;
  logic [21:0] addr_q, addr_d;
  logic [31:0] buf_q [BURST_LEN];

  logic        accept;
  logic [5:0]  count_inc;

  assign wr_ready  = (state_q == S_FILL) && (count_q < LEN6);
  assign accept    = wr_valid && wr_ready;
  // Count as it will be after this cycle, so a word arriving with flush is kept.
  assign count_inc = count_q + 6'(accept);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    beat_d     = beat_q;
    burstcnt_d = burstcnt_q;
    addr_d     = addr_q;
    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          addr_d  = wr_addr;
          count_d = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        count_d = count_inc;
        if (count_inc == LEN6) begin
          burstcnt_d = LEN6;
          beat_d     = '0;
          state_d    = S_WRITE;
        end else if (wr_flush) begin
          if (count_inc != 6'd0) begin
            burstcnt_d = count_inc;
            beat_d     = '0;
            state_d    = S_WRITE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (!ddram_waitrequest) begin
          if (beat_q == burstcnt_q - 6'd1) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      beat_q     <= '0;
      burstcnt_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      burstcnt_q <= burstcnt_d;
      addr_q     <= addr_d;
    end
  end

  // Buffer contents need no reset: they are only read for beats already filled.
  always_ff @(posedge clock) begin
    if (accept) begin
      buf_q[count_q[IDX_W-1:0]] <= wr_data;
    end
  end

  assign wr_busy         = (state_q != S_IDLE);
  assign wr_done         = (state_q == S_DONE);
  assign ddram_write     = (state_q == S_WRITE);
  assign ddram_addr      = addr_q;
  assign ddram_burstcnt  = burstcnt_q;
  assign ddram_writedata = (state_q == S_WRITE) ? buf_q[beat_q[IDX_W-1:0]] : 32'd0;

endmodule

// File: doc/param_wb_burst.md
# param_wb_burst

Burst write-back buffer for the PVR's DDRAM port, the write-direction counterpart of the parameter read cache. A PVR client opens a burst at a 22-bit word address, then streams up to BURST_LEN 32-bit words into an internal buffer. The block then issues a single Avalon-style write burst to DDRAM and reports completion. It sits between PVR write sources (tile/parameter write-back) and the shared DDRAM arbiter.

## Interface
- BURST_LEN, 32: maximum words per burst; power of two, 2..32.
- clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_addr  in  22  DDRAM word address of burst beat 0; sampled on accepted wr_start.
- wr_start  in  1  open a burst; honoured only in IDLE.
- wr_data  in  32  word to buffer.
- wr_valid  in  1  wr_data is valid; accepted when wr_valid && wr_ready.
- wr_flush  in  1  close the burst early; honoured only in FILL.
- wr_ready  out  1  block can accept a word this cycle.
- wr_busy  out  1  high in any state other than IDLE.
- wr_done  out  1  one-cycle pulse when the burst has completed, or when an empty burst is closed.
- ddram_waitrequest  in  1  arbiter stall; a beat is transferred on ddram_write && !ddram_waitrequest.
- ddram_addr  out  22  burst base address.
- ddram_burstcnt  out  6  beats in the burst, 1..BURST_LEN.
- ddram_write  out  1  write request/beat valid.
- ddram_writedata  out  32  current beat data.

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE
  - wr_ready=0.
  - On wr_start: latch wr_addr into ddram_addr, clear the word count, go to FILL.
- FILL
  - wr_ready=1 while count<BURST_LEN.
  - Each accepted word is stored at buffer[count], and count increments.
  - Count reaching BURST_LEN goes to WRITE with burstcnt=BURST_LEN.
  - On wr_flush with count (including any word accepted the same cycle) >0: go to WRITE with burstcnt=count.
  - On wr_flush with count==0: go to DONE; no DDRAM access.
  - A word accepted in the same cycle as wr_flush is included in the burst.
- WRITE
  - ddram_write=1 and ddram_writedata=buffer[beat].
  - beat increments on each !ddram_waitrequest.
  - ddram_addr and ddram_burstcnt stay constant for the whole burst.
  - When the last beat (beat==burstcnt-1) is accepted: drop ddram_write the next cycle and go to DONE.
- DONE: pulse wr_done for one cycle, then go to IDLE.
- The buffer may be registers or RAM with prefetch; ddram_writedata must be correct in every cycle ddram_write is high, including the first, and in stalled cycles.
- wr_start outside IDLE, and wr_flush outside FILL, are ignored.
- wr_valid while wr_ready=0 is ignored; no data is stored.
- Count and beat are 6-bit, which is enough for 32.
- ddram_addr is not incremented per beat; DDRAM burst addressing handles that.

## Timing
- Reset values:
  - ddram_addr=0, ddram_burstcnt=0, ddram_writedata=0.
  - ddram_write=0, wr_ready=0, wr_busy=0, wr_done=0.
  - State is IDLE.
- Reset asserted mid-FILL or mid-WRITE:
  - Outputs return to reset values asynchronously.
  - The burst is abandoned, with no completion pulse.
- wr_start at edge N: FILL from N+1; wr_ready=1 and wr_busy=1 in cycle N+1.
- Last word accepted (or flush) at edge M: wr_ready=0 from M+1, and ddram_write=1 from M+1.
- With no waitrequest, a K-beat burst holds ddram_write high for exactly K cycles.
- Each waitrequest cycle extends the burst by one cycle, with beat data held.
- Last beat accepted at edge P: ddram_write=0 and wr_done=1 in cycle P+1; IDLE from P+2.
- Flush with an empty buffer at edge M: wr_done=1 in cycle M+1; IDLE at M+2.
- Earliest next wr_start is accepted in the IDLE cycle following DONE.

## Test plan
- Full burst:
  - Stimulus: wr_start addr 22'h012340, 32 words 0..31 back-to-back, waitrequest=0.
  - Required: burstcnt=32, ddram_addr=22'h012340, 32 consecutive beats carrying 0..31, one wr_done.
- Stalled burst:
  - Stimulus: same as full burst, with waitrequest high on beats 0, 7, 31 for 3 cycles each.
  - Required: data holds during each stall, 41 write-high cycles in total, beats in order.
- Early flush:
  - Stimulus: 5 words A0..A4, wr_flush asserted together with A4.
  - Required: burstcnt=5, beats A0..A4.
- Empty flush:
  - Stimulus: wr_start then immediate wr_flush.
  - Required: ddram_write never asserts, wr_done pulses exactly once.
- Ignored inputs:
  - Stimulus: wr_start during WRITE; wr_valid in IDLE.
  - Required: latched address unchanged, no extra words stored, burst unaffected.
- Reset mid-WRITE:
  - Stimulus: reset_n low at beat 10.
  - Required: ddram_write=0 immediately, no wr_done. A subsequent 2-word burst completes correctly with burstcnt=2.
